// File: rtl/dflow_replay_reader.sv
// dflow_replay_reader: QDR read-side replay engine with a credit-bounded FWFT tuple buffer.
// Multi-pass looping over the address window is enabled by defining DFLOW_REPLAY_LOOP_EN.
module dflow_replay_reader #(
    parameter int PKT_TUPLE_WIDTH    = 104,
    parameter int PKT_LEN_WIDTH      = 16,
    parameter int QDR_ADDR_WIDTH     = 19,
    parameter int QDR_DATA_WIDTH     = 36,
    parameter int QDR_BURST_LENGTH   = 4,
    parameter int FIFO_DEPTH         = 16,
    parameter int REPLAY_COUNT_WIDTH = 32
) (
    input  logic                                      qdr_clk,
    input  logic                                      reset,
    input  logic                                      start_replay,
    output logic                                      compelete_replay,
    input  logic [QDR_ADDR_WIDTH-1:0]                 mem_addr_low,
    input  logic [QDR_ADDR_WIDTH-1:0]                 mem_addr_high,
    input  logic [REPLAY_COUNT_WIDTH-1:0]             replay_count,
    input  logic                                      init_calib_complete,
    output logic                                      user_app_rd_cmd,
    output logic [QDR_ADDR_WIDTH-1:0]                 user_app_rd_addr,
    input  logic                                      user_app_rd_valid,
    input  logic [QDR_DATA_WIDTH*QDR_BURST_LENGTH-1:0] user_app_rd_data,
    output logic [PKT_TUPLE_WIDTH-1:0]                fivetuple_data_out,
    output logic [PKT_LEN_WIDTH-1:0]                  pkt_len_out,
    output logic                                      tuple_out_vld,
    input  logic                                      tuple_out_ready,
    output logic                                      rd_overflow
);

    localparam int W  = QDR_DATA_WIDTH * QDR_BURST_LENGTH;
    localparam int EW = PKT_TUPLE_WIDTH + PKT_LEN_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAL,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic                      start_q;
    logic                      start_rise;
    logic [QDR_ADDR_WIDTH-1:0] addr;
    logic [QDR_ADDR_WIDTH-1:0] addr_low_q;
    logic [QDR_ADDR_WIDTH-1:0] addr_high_q;
    logic                      at_high;
    logic                      loop_again;

    logic [CW-1:0]             outstanding;
    logic [CW:0]               fifo_count;
    logic [CW:0]               credit;
    logic                      rd_done;

    logic [EW-1:0]             mem [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [CW-1:0]             mem_count;
    logic [EW-1:0]             out_data;
    logic                      out_vld;
    logic                      overflow;

    logic [EW-1:0]             word;
    logic                      accept;
    logic                      full;
    logic                      pop;
    logic                      push;
    logic                      drop;
    logic                      out_free;
    logic                      load_mem;
    logic                      bypass;
    logic                      push_mem;

    logic                      unused_rd_upper;
    assign unused_rd_upper = ^user_app_rd_data[W-1:EW];

    assign word       = user_app_rd_data[EW-1:0];
    assign start_rise = start_replay & ~start_q;
    assign at_high    = (addr == addr_high_q);

    // Occupancy counts the output register too, so credit covers every buffered word.
    assign fifo_count = {1'b0, mem_count} + {{CW{1'b0}}, out_vld};
    assign credit     = {1'b0, outstanding} + fifo_count;
    assign full       = (fifo_count == DEPTH_C);

    // Words returning while IDLE belong to an aborted pass and are silently discarded.
    assign accept   = user_app_rd_valid && (state != IDLE);
    assign pop      = out_vld && tuple_out_ready;
    assign push     = accept && (!full || pop);
    assign drop     = accept && full && !pop;
    assign out_free = !out_vld || pop;
    assign load_mem = out_free && (mem_count != '0);
    assign bypass   = out_free && (mem_count == '0) && push;
    assign push_mem = push && !bypass;
    assign rd_done  = accept && (outstanding != '0);

    assign user_app_rd_cmd    = (state == ISSUE) && (credit < DEPTH_C);
    assign user_app_rd_addr   = addr;
    assign compelete_replay   = (state == DONE);
    assign tuple_out_vld      = out_vld;
    assign fivetuple_data_out = out_data[EW-1:PKT_LEN_WIDTH];
    assign pkt_len_out        = out_data[PKT_LEN_WIDTH-1:0];
    assign rd_overflow        = overflow;

`ifdef DFLOW_REPLAY_LOOP_EN
    logic [REPLAY_COUNT_WIDTH-1:0] pass_cnt;
    logic [REPLAY_COUNT_WIDTH:0]   pass_next;
    logic [REPLAY_COUNT_WIDTH:0]   pass_target;

    assign pass_next   = {1'b0, pass_cnt} + (REPLAY_COUNT_WIDTH+1)'(1);
    assign pass_target = (replay_count == '0) ? (REPLAY_COUNT_WIDTH+1)'(1)
                                              : {1'b0, replay_count};
    assign loop_again  = (pass_next < pass_target);

    always_ff @(posedge qdr_clk) begin
        if (reset) begin
            pass_cnt <= '0;
        end else if ((state == IDLE) && start_rise) begin
            pass_cnt <= '0;
        end else if (user_app_rd_cmd && at_high) begin
            pass_cnt <= pass_next[REPLAY_COUNT_WIDTH-1:0];
        end
    end
`else
    logic unused_replay_count;
    assign unused_replay_count = ^replay_count;
    assign loop_again = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_rise) state_nxt = WAIT_CAL;
            WAIT_CAL: if (init_calib_complete) state_nxt = ISSUE;
            ISSUE:    if (user_app_rd_cmd && at_high && !loop_again) state_nxt = DRAIN;
            DRAIN:    if ((outstanding == '0) && (fifo_count == '0) && !out_vld) state_nxt = DONE;
            DONE:     if (!start_replay) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge qdr_clk) begin
        if (reset) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            addr        <= '0;
            addr_low_q  <= '0;
            addr_high_q <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= start_replay;
            if ((state == IDLE) && start_rise) begin
                addr_low_q  <= mem_addr_low;
                addr_high_q <= mem_addr_high;
                addr        <= mem_addr_low;
            end else if (user_app_rd_cmd) begin
                // Plain increment wraps modulo 2^QDR_ADDR_WIDTH, which handles low > high windows.
                if (at_high) begin
                    if (loop_again) addr <= addr_low_q;
                end else begin
                    addr <= addr + QDR_ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge qdr_clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({user_app_rd_cmd, rd_done})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // The output register is the FIFO head; an empty buffer lets a returning word bypass into it.
    always_ff @(posedge qdr_clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_data  <= '0;
            out_vld   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (push_mem) wr_ptr <= wr_ptr + PW'(1);
            if (out_free) begin
                if (load_mem) begin
                    out_data <= mem[rd_ptr];
                    out_vld  <= 1'b1;
                    rd_ptr   <= rd_ptr + PW'(1);
                end else if (push) begin
                    out_data <= word;
                    out_vld  <= 1'b1;
                end else begin
                    out_vld  <= 1'b0;
                end
            end
            case ({push_mem, load_mem})
                2'b10:   mem_count <= mem_count + CW'(1);
                2'b01:   mem_count <= mem_count - CW'(1);
                default: mem_count <= mem_count;
            endcase
        end
    end

    always_ff @(posedge qdr_clk) begin
        if (push_mem) mem[wr_ptr] <= word;
    end

endmodule

// File: tb/tb_dflow_replay_reader.sv
// tb_dflow_replay_reader: table-driven replay scenarios against a QDR read model and tuple scoreboard.
// Build with DFLOW_REPLAY_LOOP_EN defined to expect multi-pass looping.
module tb_dflow_replay_reader;

    localparam int AW    = 19;
    localparam int TW    = 104;
    localparam int LW    = 16;
    localparam int W     = 144;
    localparam int RW    = 32;
    localparam int DEPTH = 16;
    localparam int NVEC  = 8;

    logic           qdr_clk;
    logic           reset;
    logic           start_replay;
    logic           compelete_replay;
    logic [AW-1:0]  mem_addr_low;
    logic [AW-1:0]  mem_addr_high;
    logic [RW-1:0]  replay_count;
    logic           init_calib_complete;
    logic           user_app_rd_cmd;
    logic [AW-1:0]  user_app_rd_addr;
    logic           user_app_rd_valid;
    logic [W-1:0]   user_app_rd_data;
    logic [TW-1:0]  fivetuple_data_out;
    logic [LW-1:0]  pkt_len_out;
    logic           tuple_out_vld;
    logic           tuple_out_ready;
    logic           rd_overflow;

    dflow_replay_reader dut (
        .qdr_clk             (qdr_clk),
        .reset               (reset),
        .start_replay        (start_replay),
        .compelete_replay    (compelete_replay),
        .mem_addr_low        (mem_addr_low),
        .mem_addr_high       (mem_addr_high),
        .replay_count        (replay_count),
        .init_calib_complete (init_calib_complete),
        .user_app_rd_cmd     (user_app_rd_cmd),
        .user_app_rd_addr    (user_app_rd_addr),
        .user_app_rd_valid   (user_app_rd_valid),
        .user_app_rd_data    (user_app_rd_data),
        .fivetuple_data_out  (fivetuple_data_out),
        .pkt_len_out         (pkt_len_out),
        .tuple_out_vld       (tuple_out_vld),
        .tuple_out_ready     (tuple_out_ready),
        .rd_overflow         (rd_overflow)
    );

    typedef struct {
        logic [AW-1:0] low;
        logic [AW-1:0] high;
        int            lat;
        int            ready_mode;
        int            cal_delay;
        int            rcount;
        int            exp_words;
        int            pass_words;
        logic [AW-1:0] exp_first;
    } vec_t;

    vec_t vecs[NVEC];

    int total = 0;
    int bad   = 0;

    int cyc        = 0;
    int lat        = 5;
    int ready_mode = 0;

    logic [AW-1:0] pend_addr[$];
    int            pend_due[$];
    logic [AW-1:0] iss_q[$];
    logic [TW-1:0] rx_t[$];
    logic [LW-1:0] rx_l[$];

    int issued, popped, max_inflight, max_gap, max_iss_gap;
    int last_pop, last_iss, first_valid_cyc, first_vld_cyc, hold_err;
    logic          hold_pending;
    logic [TW+LW-1:0] held;

    initial begin
        qdr_clk = 1'b0;
        forever #5 qdr_clk = ~qdr_clk;
    end

    function automatic logic [TW-1:0] exp_tuple(input logic [AW-1:0] a);
        return {8'h5A, 77'd0, a};
    endfunction

    function automatic logic [W-1:0] exp_word(input logic [AW-1:0] a);
        return {24'hC3C3C3, exp_tuple(a), a[15:0]};
    endfunction

    function automatic vec_t mk(input logic [AW-1:0] low, input logic [AW-1:0] high,
                                input int l, input int rm, input int cd, input int rc,
                                input int ew, input int pw, input logic [AW-1:0] ef);
        vec_t v;
        v.low = low; v.high = high; v.lat = l; v.ready_mode = rm; v.cal_delay = cd;
        v.rcount = rc; v.exp_words = ew; v.pass_words = pw; v.exp_first = ef;
        return v;
    endfunction

    // QDR read model, downstream ready pattern and output scoreboard, all on the falling edge.
    initial begin
        user_app_rd_valid = 1'b0;
        user_app_rd_data  = '0;
        tuple_out_ready   = 1'b0;
        forever begin
            @(negedge qdr_clk);
            cyc++;
            user_app_rd_valid = 1'b0;
            user_app_rd_data  = '0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                user_app_rd_valid = 1'b1;
                user_app_rd_data  = exp_word(pend_addr[0]);
                pend_due.delete(0);
                pend_addr.delete(0);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (user_app_rd_cmd) begin
                pend_addr.push_back(user_app_rd_addr);
                pend_due.push_back(cyc + lat);
                iss_q.push_back(user_app_rd_addr);
                if (issued > 0 && cyc - last_iss > max_iss_gap) max_iss_gap = cyc - last_iss;
                last_iss = cyc;
                issued++;
            end
            case (ready_mode)
                0:       tuple_out_ready = 1'b1;
                1:       tuple_out_ready = (cyc % 4 == 0);
                default: tuple_out_ready = (cyc % 2 == 0);
            endcase
            if (hold_pending) begin
                if (!tuple_out_vld || {fivetuple_data_out, pkt_len_out} !== held) hold_err++;
            end
            hold_pending = tuple_out_vld && !tuple_out_ready;
            held         = {fivetuple_data_out, pkt_len_out};
            if (tuple_out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (tuple_out_vld && tuple_out_ready) begin
                rx_t.push_back(fivetuple_data_out);
                rx_l.push_back(pkt_len_out);
                if (popped > 0 && cyc - last_pop > max_gap) max_gap = cyc - last_pop;
                last_pop = cyc;
                popped++;
            end
            if (issued - popped > max_inflight) max_inflight = issued - popped;
        end
    end

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic clear_scoreboard();
        iss_q.delete();
        rx_t.delete();
        rx_l.delete();
        issued = 0; popped = 0; max_inflight = 0; max_gap = 0; max_iss_gap = 0;
        last_pop = 0; last_iss = 0; first_valid_cyc = -1; first_vld_cyc = -1;
        hold_err = 0; hold_pending = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge qdr_clk);
        #1;
    endtask

    task automatic apply_stimulus(input int vi, input vec_t v, output logic done_seen);
        lat           = v.lat;
        ready_mode    = v.ready_mode;
        mem_addr_low  = v.low;
        mem_addr_high = v.high;
        replay_count  = v.rcount;
        init_calib_complete = (v.cal_delay == 0);
        clear_scoreboard();
        start_replay = 1'b1;
        if (v.cal_delay > 0) begin
            tick(v.cal_delay);
            check_output($sformatf("v%0d_no_cmd_before_cal", vi), issued, 0);
            init_calib_complete = 1'b1;
        end
        done_seen = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            tick(1);
            if (compelete_replay) begin
                done_seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_vector(input int vi, input vec_t v, input logic done_seen);
        logic [AW-1:0] ea;
        check_output($sformatf("v%0d_done", vi), done_seen, 1);
        check_output($sformatf("v%0d_issued", vi), issued, v.exp_words);
        check_output($sformatf("v%0d_rx_count", vi), rx_t.size(), v.exp_words);
        for (int i = 0; i < v.exp_words; i++) begin
            ea = v.exp_first + AW'(i % v.pass_words);
            if (i < iss_q.size())
                check_output($sformatf("v%0d_addr%0d", vi, i), iss_q[i], ea);
            if (i < rx_t.size()) begin
                check_output($sformatf("v%0d_tuple%0d", vi, i), rx_t[i], exp_tuple(ea));
                check_output($sformatf("v%0d_len%0d", vi, i), rx_l[i], ea[15:0]);
            end
        end
        check_output($sformatf("v%0d_overflow", vi), rd_overflow, 0);
        check_output($sformatf("v%0d_inflight_le_depth", vi), max_inflight <= DEPTH, 1);
        check_output($sformatf("v%0d_hold_stable", vi), hold_err, 0);
        check_output($sformatf("v%0d_first_latency", vi), first_vld_cyc - first_valid_cyc, 1);
        if (v.ready_mode == 0 && v.exp_words > 1) begin
            check_output($sformatf("v%0d_out_gap", vi), max_gap, 1);
            check_output($sformatf("v%0d_issue_gap", vi), max_iss_gap, 1);
        end
        start_replay = 1'b0;
        tick(2);
        check_output($sformatf("v%0d_back_to_idle", vi), compelete_replay, 0);
    endtask

    initial begin
        logic done_seen;
        int   issued_at_reset;
        logic reached;

        vecs[0] = mk(19'h00000, 19'h0000F, 5,  0, 0,   1, 16, 16, 19'h00000);
        vecs[1] = mk(19'h00000, 19'h0000F, 20, 1, 0,   1, 16, 16, 19'h00000);
        vecs[2] = mk(19'h00007, 19'h00007, 5,  0, 0,   1, 1,  1,  19'h00007);
        vecs[3] = mk(19'h7FFFE, 19'h00001, 5,  0, 0,   1, 4,  4,  19'h7FFFE);
        vecs[4] = mk(19'h00000, 19'h0000F, 5,  0, 100, 1, 16, 16, 19'h00000);
        vecs[5] = mk(19'h00064, 19'h00083, 3,  2, 0,   1, 32, 32, 19'h00064);
        vecs[6] = mk(19'h00000, 19'h00027, 20, 1, 0,   1, 40, 40, 19'h00000);
`ifdef DFLOW_REPLAY_LOOP_EN
        vecs[7] = mk(19'h00000, 19'h00003, 5,  0, 0,   3, 12, 4,  19'h00000);
`else
        vecs[7] = mk(19'h00000, 19'h00003, 5,  0, 0,   3, 4,  4,  19'h00000);
`endif

        reset = 1'b1;
        start_replay = 1'b0;
        mem_addr_low = '0;
        mem_addr_high = '0;
        replay_count = 32'd1;
        init_calib_complete = 1'b1;
        clear_scoreboard();
        tick(3);
        check_output("rst_complete", compelete_replay, 0);
        check_output("rst_rd_cmd", user_app_rd_cmd, 0);
        check_output("rst_rd_addr", user_app_rd_addr, 0);
        check_output("rst_vld", tuple_out_vld, 0);
        check_output("rst_tuple", fivetuple_data_out, 0);
        check_output("rst_len", pkt_len_out, 0);
        check_output("rst_overflow", rd_overflow, 0);
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(i, vecs[i], done_seen);
            check_vector(i, vecs[i], done_seen);
        end

        // Reset in the middle of a pass, with reads still in flight at the QDR model.
        lat = 5; ready_mode = 0;
        mem_addr_low = 19'h0; mem_addr_high = 19'hF; replay_count = 32'd1;
        clear_scoreboard();
        start_replay = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            tick(1);
            if (popped >= 8) begin
                reached = 1'b1;
                break;
            end
        end
        check_output("mid_reached_8th", reached, 1);
        reset = 1'b1;
        start_replay = 1'b0;
        tick(1);
        issued_at_reset = issued;
        check_output("mid_rst_vld", tuple_out_vld, 0);
        check_output("mid_rst_rd_cmd", user_app_rd_cmd, 0);
        check_output("mid_rst_tuple", fivetuple_data_out, 0);
        check_output("mid_rst_len", pkt_len_out, 0);
        check_output("mid_rst_complete", compelete_replay, 0);
        reset = 1'b0;
        tick(40);
        check_output("late_valid_no_overflow", rd_overflow, 0);
        check_output("late_valid_no_output", tuple_out_vld, 0);
        check_output("no_cmd_after_reset", issued, issued_at_reset);
        check_output("late_valid_delivered", pend_due.size(), 0);

        apply_stimulus(100, vecs[0], done_seen);
        check_vector(100, vecs[0], done_seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
